// File: rtl/m16_accum.sv
// m16_accum
// Burst accumulator for the unsigned 32-bit products of the 16x16 approximate
// multiplier. Sums products over a valid/ready burst terminated by in_last,
// then holds the saturated sum, beat count and overflow flag on an output
// valid/ready handshake until the consumer takes them.
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   in_prod / in_last valid
//   in_ready   a beat is accepted this cycle (registered-state decode)
//   in_prod    32-bit unsigned product
//   in_last    final beat of the burst
//   out_valid  result fields valid (registered-state decode)
//   out_ready  consumer takes the result this cycle
//   out_acc    saturated unsigned sum (running partial outside HOLD)
//   out_count  beats accepted, saturating
//   out_ovf    sticky: the sum saturated during this burst
module m16_accum #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_prod,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [ACC_W:0]   sum_sat;

  // Returns {carry, saturated sum}: the add is done one bit wider so the
  // carry-out can be detected and the low bits clamped to all ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [31:0]      b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(b);
    if (s[ACC_W]) s = {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  // Beat counter sticks at all ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + CNT_W'(1);
  endfunction

  always_comb begin
    sum_sat = sat_add(acc, in_prod);
  end

  assign in_ready  = (state != S_HOLD);
  assign out_valid = (state == S_HOLD);
  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            acc   <= ACC_W'(in_prod);
            count <= CNT_W'(1);
            ovf   <= 1'b0;
            state <= in_last ? S_HOLD : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc   <= sum_sat[ACC_W-1:0];
            ovf   <= ovf | sum_sat[ACC_W];
            count <= sat_inc(count);
            if (in_last) state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m16_accum.sv
// Testbench for m16_accum. Two instances share one stimulus stream: dut0 at
// the default widths (ACC_W=40, CNT_W=8) and dut1 narrowed (ACC_W=33,
// CNT_W=2) so sum and count saturation are exercised by the same bursts.
// A burst-level model (exact running sum and beat count, clamped only when
// compared) is checked against both instances every cycle, plus literal
// expectations for each directed scenario.
module tb_m16_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        in_ready0, out_valid0, out_ovf0;
  logic [39:0] out_acc0;
  logic [7:0]  out_count0;
  logic        in_ready1, out_valid1, out_ovf1;
  logic [32:0] out_acc1;
  logic [1:0]  out_count1;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  localparam logic [63:0] MAXA0 = 64'h0000_00FF_FFFF_FFFF;
  localparam logic [63:0] MAXA1 = 64'h0000_0001_FFFF_FFFF;
  localparam logic [63:0] MAXC0 = 64'd255;
  localparam logic [63:0] MAXC1 = 64'd3;

  always #5 clk = ~clk;

  m16_accum #(.ACC_W(40), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid0),
    .out_ready(out_ready), .out_acc(out_acc0), .out_count(out_count0),
    .out_ovf(out_ovf0)
  );

  m16_accum #(.ACC_W(33), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_prod(in_prod), .in_last(in_last), .out_valid(out_valid1),
    .out_ready(out_ready), .out_acc(out_acc1), .out_count(out_count1),
    .out_ovf(out_ovf1)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst model: exact sum and beat count of the current burst, and whether
  // a finished result is waiting to be taken.
  logic [63:0] m_sum;
  int          m_beats;
  bit          m_hold;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sum <= 64'd0; m_beats <= 0; m_hold <= 1'b0;
    end else if (m_hold) begin
      if (out_ready) begin
        m_sum <= 64'd0; m_beats <= 0; m_hold <= 1'b0;
      end
    end else if (in_valid) begin
      m_sum   <= m_sum + 64'(in_prod);
      m_beats <= m_beats + 1;
      if (in_last) m_hold <= 1'b1;
    end
  end

  logic [63:0] e_cnt;
  always @(negedge clk) begin
    if (chk_en) begin
      e_cnt = 64'(m_beats);
      chk("m_in_ready0",  64'(in_ready0),  64'(!m_hold));
      chk("m_out_valid0", 64'(out_valid0), 64'(m_hold));
      chk("m_out_acc0",   64'(out_acc0),   (m_sum > MAXA0) ? MAXA0 : m_sum);
      chk("m_out_count0", 64'(out_count0), (e_cnt > MAXC0) ? MAXC0 : e_cnt);
      chk("m_out_ovf0",   64'(out_ovf0),   64'(m_sum > MAXA0));
      chk("m_in_ready1",  64'(in_ready1),  64'(!m_hold));
      chk("m_out_valid1", 64'(out_valid1), 64'(m_hold));
      chk("m_out_acc1",   64'(out_acc1),   (m_sum > MAXA1) ? MAXA1 : m_sum);
      chk("m_out_count1", 64'(out_count1), (e_cnt > MAXC1) ? MAXC1 : e_cnt);
      chk("m_out_ovf1",   64'(out_ovf1),   64'(m_sum > MAXA1));
    end
  end

  // Called at a falling edge; presents one beat for exactly one rising edge.
  task automatic send(input logic [31:0] p, input logic last);
    in_valid = 1'b1; in_prod = p; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_prod = 32'hDEAD_BEEF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for a result, then takes it with a one-cycle out_ready.
  task automatic take();
    int n = 0;
    while (!out_valid0 && n < 20) begin @(negedge clk); n++; end
    chk("take_wait_valid", 64'(out_valid0), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_prod = '0; in_last = 1'b0; out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_en = 1'b1;
    chk("rst_in_ready",  64'(in_ready0),  64'd1);
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_out_acc",   64'(out_acc0),   64'd0);
    chk("rst_out_count", 64'(out_count0), 64'd0);
    chk("rst_out_ovf",   64'(out_ovf0),   64'd0);
    rst_n = 1'b1;
    idle(1);

    // Single beat
    send(32'h0000_0006, 1'b1);
    chk("single_valid", 64'(out_valid0), 64'd1);
    chk("single_acc",   64'(out_acc0),   64'd6);
    chk("single_count", 64'(out_count0), 64'd1);
    chk("single_ovf",   64'(out_ovf0),   64'd0);
    chk("single_ready", 64'(in_ready0),  64'd0);
    take();

    // Four beats with two idle cycles between them
    send(32'd1, 1'b0); idle(2);
    send(32'd2, 1'b0); idle(2);
    send(32'd3, 1'b0); idle(2);
    chk("burst4_no_early_valid", 64'(out_valid0), 64'd0);
    send(32'hFFFF_FFFF, 1'b1);
    chk("burst4_acc",   64'(out_acc0),   64'h01_0000_0005);
    chk("burst4_count", 64'(out_count0), 64'd4);
    chk("burst4_ovf",   64'(out_ovf0),   64'd0);
    take();

    // Sum saturation on the 33-bit instance
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b0);
    send(32'hFFFF_FFFF, 1'b1);
    chk("sat_acc33",  64'(out_acc1), 64'h1_FFFF_FFFF);
    chk("sat_ovf33",  64'(out_ovf1), 64'd1);
    chk("sat_acc40",  64'(out_acc0), 64'h2_FFFF_FFFD);
    chk("sat_ovf40",  64'(out_ovf0), 64'd0);
    take();
    send(32'd5, 1'b1);
    chk("sat_next_acc33", 64'(out_acc1), 64'd5);
    chk("sat_next_ovf33", 64'(out_ovf1), 64'd0);
    take();

    // Output backpressure with a beat pending upstream
    send(32'd8, 1'b1);
    in_valid = 1'b1; in_prod = 32'd9; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready_low", 64'(in_ready0),  64'd0);
      chk("bp_acc_hold",  64'(out_acc0),   64'd8);
      chk("bp_valid",     64'(out_valid0), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_after_hs_valid", 64'(out_valid0), 64'd0);
    chk("bp_after_hs_ready", 64'(in_ready0),  64'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk("bp_pending_acc",   64'(out_acc0),   64'd9);
    chk("bp_pending_valid", 64'(out_valid0), 64'd1);
    take();

    // Count saturation on the 2-bit counter
    for (int i = 0; i < 6; i++) send(32'd1, (i == 5));
    chk("cnt_sat_count2", 64'(out_count1), 64'd3);
    chk("cnt_sat_acc2",   64'(out_acc1),   64'd6);
    chk("cnt_sat_ovf2",   64'(out_ovf1),   64'd0);
    chk("cnt_count8",     64'(out_count0), 64'd6);
    take();

    // Reset in the middle of a burst
    send(32'd7, 1'b0);
    send(32'd9, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_acc",   64'(out_acc0),   64'd0);
    chk("rst_mid_valid", 64'(out_valid0), 64'd0);
    send(32'd4, 1'b1);
    chk("rst_mid_new_acc",   64'(out_acc0),   64'd4);
    chk("rst_mid_new_count", 64'(out_count0), 64'd1);
    take();
    idle(2);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/m16_accum.md
# m16_accum

Sequential accumulator directly downstream of the 16x16 approximate recursive multiplier. It consumes the multiplier's 32-bit unsigned products one per beat over a valid/ready handshake and sums a burst of products terminated by `in_last`. It then presents the saturated sum, beat count and overflow flag on an output handshake. Together with the multiplier it forms a dot-product/MAC datapath used for error-metric runs over long operand streams.

## Interface
Parameters:
- `ACC_W`, 40: accumulator width in bits, at least 32.
- `CNT_W`, 8: beat-counter width in bits.

Ports (clock and reset first):
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  synchronous active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  input  1  `in_prod` / `in_last` are valid.
- `in_ready`  output  1  block accepts a beat this cycle.
- `in_prod`  input  32  unsigned product from the multiplier `Y` output.
- `in_last`  input  1  final beat of the current burst.
- `out_valid`  output  1  result fields are valid.
- `out_ready`  input  1  consumer takes the result this cycle.
- `out_acc`  output  ACC_W  saturated unsigned sum of the burst.
- `out_count`  output  CNT_W  beats accepted in the burst, saturating.
- `out_ovf`  output  1  sticky flag: the sum saturated during the burst.

## Operation
- An accept occurs when `in_valid && in_ready`. An output handshake occurs when `out_valid && out_ready`.
- FSM states: IDLE, ACCUM, HOLD. Reset state is IDLE.
  - IDLE: `in_ready`=1. On accept, acc := zero-extended `in_prod` and count := 1. Go to HOLD if `in_last`, otherwise ACCUM.
  - ACCUM: `in_ready`=1. On accept, acc := sat(acc + `in_prod`) and count := sat(count + 1). Go to HOLD if `in_last`. With no accept, hold all state.
  - HOLD: `in_ready`=0 and `out_valid`=1. Outputs are stable until the output handshake. On handshake, go to IDLE and clear acc, count and ovf.
- Arithmetic rules:
  - The sum is computed at ACC_W+1 bits.
  - If the carry-out is set, acc := all ones (2^ACC_W−1) and ovf := 1.
  - ovf stays set until the result is taken.
- Count rules:
  - count saturates at 2^CNT_W−1 and does not wrap.
  - A count saturation does not set ovf.
- Single-beat burst (`in_last` on the first beat): the result equals that product with count = 1.
- Beats presented while in HOLD are not accepted. `in_ready`=0, so the upstream stage must hold them.
- `in_prod` and `in_last` are ignored when `in_valid`=0.
- Reset mid-burst or in HOLD: on the next edge, state returns to IDLE and the partial sum is discarded. No result is emitted.

## Timing
- Reset values:
  - `in_ready`=1
  - `out_valid`=0
  - `out_acc`=0
  - `out_count`=0
  - `out_ovf`=0
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
- `out_acc`, `out_count` and `out_ovf` are registered. Outside HOLD they show the running partial values.
- Latency: `out_valid` rises in the cycle after the edge that accepts the `in_last` beat.
- Throughput:
  - One beat per cycle inside a burst.
  - A minimum of 1 HOLD cycle per burst, so a back-to-back burst can start the cycle after the output handshake.
- Upstream is a combinational multiplier. The product must be presented with `in_valid` in the same cycle.

## Test plan
- **Single beat:** `in_prod`=0x0000_0006, `in_last`=1 → next cycle `out_valid`=1, `out_acc`=6, `out_count`=1, `out_ovf`=0, `in_ready`=0.
- **Four-beat burst:** products 1, 2, 3, 0xFFFF_FFFF with gaps (`in_valid` low for 2 cycles between beats) → `out_acc`=0x01_0000_0005, `out_count`=4, no output before the last beat.
- **Saturation:** ACC_W=33, three beats of 0xFFFF_FFFF → `out_acc`=0x1_FFFF_FFFF, `out_ovf`=1. The next burst of 5 → `out_acc`=5, `out_ovf`=0.
- **Output backpressure:** hold `out_ready`=0 for 5 cycles with `in_valid`=1 pending → outputs stable and `in_ready`=0 throughout. When `out_ready` rises, the handshake occurs and the pending beat is accepted the following cycle.
- **Count saturation:** CNT_W=2, six beats of 1 → `out_count`=3, `out_acc`=6, `out_ovf`=0.
- **Reset mid-burst:** accept 7 and 9, pull `rst_n` low for one cycle, then send a single beat of 4 with `in_last` → `out_acc`=4, `out_count`=1, no stale result.
